// File: rtl/result_accum_pkg.sv
// Shared types and helpers for the adder result accumulator.
package result_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } accum_state_e;

    // Each adder result carries the carry-out above the sum bits.
    function automatic int res_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Valid shift register that re-times issue-side valids to the adder output.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_i,
    output logic tap_o,
    output logic any_o
);

    logic [DEPTH-1:0] stage_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tap_o = stage_q[DEPTH-1];
    assign any_o = |stage_q;

endmodule

// File: rtl/adder_result_accum.sv
// Aligns adder results to issue valids and accumulates BURST_LEN of them per output total.
// Build option: RESULT_ACCUM_SAT_EN makes the accumulator saturate instead of wrapping.
module adder_result_accum
    import result_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int ADDER_LAT  = 2,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] sum,
    input  logic                  Cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_acc,
    output logic                  out_ovf,
    output logic                  drop_err,
    output logic                  busy,
    output logic [1:0]            dbg_state_o
);

    // Output handshake: a total transfers on a rising edge where out_valid & out_ready;
    // out_acc/out_ovf stay stable while out_valid is high and out_ready is low.

    localparam int RES_W = res_width(DATA_WIDTH);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

    accum_state_e         state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [RES_W-1:0]     pend_q, pend_d;
    logic                 pend_full_q, pend_full_d;
    logic                 drop_q, drop_d;

    logic                 v_al;
    logic                 dl_any;
    logic [RES_W-1:0]     res_w;
    logic [ACC_WIDTH-1:0] res_ext;
    logic [ACC_WIDTH-1:0] pend_ext;
    logic [ACC_WIDTH:0]   sum_full;
    logic [ACC_WIDTH-1:0] acc_add;
    logic [ACC_WIDTH-1:0] seed_acc;
    logic [CNT_W-1:0]     seed_cnt;
    logic [CNT_W-1:0]     cnt_inc;

    valid_delay_line #(
        .DEPTH (ADDER_LAT)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .valid_i (in_valid),
        .tap_o   (v_al),
        .any_o   (dl_any)
    );

    assign res_w    = {Cout, sum};
    assign res_ext  = {{(ACC_WIDTH-RES_W){1'b0}}, res_w};
    assign pend_ext = {{(ACC_WIDTH-RES_W){1'b0}}, pend_q};
    assign sum_full = {1'b0, acc_q} + {1'b0, res_ext};
    assign cnt_inc  = cnt_q + 1'b1;

`ifdef RESULT_ACCUM_SAT_EN
    assign acc_add = sum_full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_full[ACC_WIDTH-1:0];
`else
    assign acc_add = sum_full[ACC_WIDTH-1:0];
`endif

    // Two seeds of at most RES_W bits each always fit, since ACC_WIDTH > RES_W.
    assign seed_acc = (pend_full_q ? pend_ext : '0) + (v_al ? res_ext : '0);
    assign seed_cnt = {{(CNT_W-1){1'b0}}, pend_full_q} + {{(CNT_W-1){1'b0}}, v_al};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        drop_d      = drop_q;
        case (state_q)
            IDLE: begin
                if (v_al) begin
                    acc_d   = res_ext;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (v_al) begin
                    acc_d = acc_add;
                    ovf_d = ovf_q | sum_full[ACC_WIDTH];
                    cnt_d = cnt_inc;
                    if (cnt_inc == BURST_CNT) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d       = seed_acc;
                    cnt_d       = seed_cnt;
                    ovf_d       = 1'b0;
                    pend_full_d = 1'b0;
                    if (seed_cnt == '0) begin
                        state_d = IDLE;
                    end else if (seed_cnt == BURST_CNT) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                end else if (v_al) begin
                    if (!pend_full_q) begin
                        pend_d      = res_w;
                        pend_full_d = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid   = (state_q == HOLD);
    assign out_acc     = acc_q;
    assign out_ovf     = ovf_q;
    assign drop_err    = drop_q;
    assign busy        = (state_q != IDLE) | pend_full_q | dl_any;
    assign dbg_state_o = state_q;

endmodule
